// File: rtl/button_event_capture.sv
// Syncs and debounces four buttons, latching the first press into a clear-on-read event word.
// Latency: raw-to-level DEBOUNCE_CYCLES+2 edges, event one edge later; no backpressure, poll only freezes the word.
module button_event_capture #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  btn_raw,
   input  logic        poll,
   output logic [31:0] event_word,
   output logic [3:0]  btn_level,
   output logic [3:0]  press_pulse
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HELD, READING} state_t;

   logic [3:0]       sync1, sync2, stable, stable_q;
   logic [CNT_W-1:0] cnt [4];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_q <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         stable_q <= stable;
         for (int i = 0; i < 4; i++) begin
            // any sample matching the stable level restarts the qualification window
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign btn_level   = stable;
   assign press_pulse = stable & ~stable_q;

   state_t     state, state_n;
   logic       poll_q, poll_fall;
   logic       ev_vld, ev_vld_n, ev_ovf, ev_ovf_n;
   logic [1:0] ev_col, ev_col_n;
   logic       sh_vld, sh_vld_n, sh_ovf, sh_ovf_n;
   logic [1:0] sh_col, sh_col_n;
   logic       any_pulse, multi_pulse;
   logic [1:0] win_col;

   assign any_pulse   = |press_pulse;
   assign multi_pulse = |(press_pulse & (press_pulse - 4'd1));
   assign poll_fall   = poll_q & ~poll;

   always_comb begin
      win_col = 2'd3;
      if (press_pulse[0])      win_col = 2'd0;
      else if (press_pulse[1]) win_col = 2'd1;
      else if (press_pulse[2]) win_col = 2'd2;
   end

   always_comb begin
      state_n  = state;
      ev_vld_n = ev_vld;
      ev_col_n = ev_col;
      ev_ovf_n = ev_ovf;
      sh_vld_n = sh_vld;
      sh_col_n = sh_col;
      sh_ovf_n = sh_ovf;
      case (state)
         IDLE, HELD: begin
            if (poll) begin
               // a read is starting: the event word freezes, new presses park in the shadow
               state_n = READING;
               if (any_pulse) begin
                  sh_vld_n = 1'b1;
                  sh_col_n = win_col;
                  sh_ovf_n = multi_pulse;
               end
            end else if (any_pulse) begin
               if (state == IDLE) begin
                  ev_vld_n = 1'b1;
                  ev_col_n = win_col;
                  ev_ovf_n = multi_pulse;
                  state_n  = HELD;
               end else begin
                  ev_ovf_n = 1'b1;
               end
            end
         end
         READING: begin
            if (poll_fall) begin
               ev_vld_n = 1'b0;
               ev_col_n = 2'd0;
               ev_ovf_n = 1'b0;
               sh_vld_n = 1'b0;
               sh_col_n = 2'd0;
               sh_ovf_n = 1'b0;
               state_n  = IDLE;
               if (sh_vld) begin
                  ev_vld_n = 1'b1;
                  ev_col_n = sh_col;
                  ev_ovf_n = sh_ovf | any_pulse;
                  state_n  = HELD;
               end else if (any_pulse) begin
                  ev_vld_n = 1'b1;
                  ev_col_n = win_col;
                  ev_ovf_n = multi_pulse;
                  state_n  = HELD;
               end
            end else if (any_pulse) begin
               if (sh_vld) begin
                  sh_ovf_n = 1'b1;
               end else begin
                  sh_vld_n = 1'b1;
                  sh_col_n = win_col;
                  sh_ovf_n = multi_pulse;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         poll_q <= 1'b0;
         ev_vld <= 1'b0;
         ev_col <= 2'd0;
         ev_ovf <= 1'b0;
         sh_vld <= 1'b0;
         sh_col <= 2'd0;
         sh_ovf <= 1'b0;
      end else begin
         state  <= state_n;
         poll_q <= poll;
         ev_vld <= ev_vld_n;
         ev_col <= ev_col_n;
         ev_ovf <= ev_ovf_n;
         sh_vld <= sh_vld_n;
         sh_col <= sh_col_n;
         sh_ovf <= sh_ovf_n;
      end
   end

   assign event_word = {28'd0, ev_ovf, ev_col, ev_vld};

endmodule
